// File: rtl/multiword_add_pkg.sv
// Shared types and sizing helpers for the multi-word sequential adder.
package multiword_add_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_WORDS = 4;

    // Word counter width; at least one bit so a single-word build still elaborates.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/word_rca.sv
// Combinational WIDTH-bit ripple-carry word adder with carry in/out.
module word_rca #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    output logic [WIDTH-1:0] s_o,
    output logic             c_o
);

    logic [WIDTH:0] c;

    assign c[0] = c_i;

    // One full adder per bit, carry rippling from bit 0 upward.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o = c[WIDTH];

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential multi-word adder: streams LS-word-first operand pairs through one
// word_rca, chaining the carry, with a single registered valid/ready output.
// Optional feature: define MULTIWORD_OVF_EN to add the signed-overflow output out_ovf.
module multiword_add_seq
    import multiword_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int WORDS = DEF_WORDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_first,
    input  logic             in_last,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_last,
    output logic             out_carry,
    output logic             len_err,
`ifdef MULTIWORD_OVF_EN
    output logic             out_ovf,
`endif
    output logic             busy
);

    localparam int CW = cnt_width(WORDS);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_eff;
    logic              carry_q, carry_d;
    logic              vld_q, vld_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              last_q, last_d;
    logic              cout_q, cout_d;
    logic              err_q, err_d;
`ifdef MULTIWORD_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    logic              acc, first_eff, at_max, last_eff, cin;
    logic [WIDTH-1:0]  s;
    logic              c;

    word_rca #(.WIDTH(WIDTH)) u_rca (
        .a_i (in_a),
        .b_i (in_b),
        .c_i (cin),
        .s_o (s),
        .c_o (c)
    );

    assign in_ready = !vld_q || out_ready;

    // Next-state: FSM, word counter, carry chain and output register load.
    always_comb begin
        acc       = in_valid && in_ready;
        // In IDLE every beat starts an operation, flagged or not.
        first_eff = in_first || (state_q == IDLE);
        cnt_eff   = first_eff ? '0 : cnt_q;
        cin       = first_eff ? carry_in : carry_q;
        at_max    = (cnt_eff == CW'(WORDS - 1));
        last_eff  = in_last || at_max;

        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        vld_d   = vld_q && !out_ready;
        sum_d   = sum_q;
        last_d  = last_q;
        cout_d  = cout_q;
        err_d   = err_q;
`ifdef MULTIWORD_OVF_EN
        ovf_d   = ovf_q;
`endif

        if (acc) begin
            vld_d   = 1'b1;
            sum_d   = s;
            last_d  = last_eff;
            cout_d  = last_eff & c;
            carry_d = c;
`ifdef MULTIWORD_OVF_EN
            ovf_d   = last_eff && (in_a[WIDTH-1] == in_b[WIDTH-1]) && (s[WIDTH-1] != in_a[WIDTH-1]);
`endif
            if (last_eff) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d = RUN;
                cnt_d   = cnt_eff + CW'(1);
            end
            // Missing first, abort by a new first, or forced termination.
            if ((!in_first && state_q == IDLE) || (in_first && state_q == RUN) ||
                (at_max && !in_last))
                err_d = 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            vld_q   <= 1'b0;
            sum_q   <= '0;
            last_q  <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MULTIWORD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            vld_q   <= vld_d;
            sum_q   <= sum_d;
            last_q  <= last_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
`ifdef MULTIWORD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign out_valid = vld_q;
    assign out_sum   = sum_q;
    assign out_last  = last_q;
    assign out_carry = cout_q;
    assign len_err   = err_q;
    assign busy      = (state_q == RUN);
`ifdef MULTIWORD_OVF_EN
    assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_multiword_add_seq.sv
// Scoreboard bench for multiword_add_seq (WIDTH=16, WORDS=4).
module tb_multiword_add_seq;

    localparam int W = 16;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_first = 1'b0;
    logic         in_last = 1'b0;
    logic         carry_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_sum;
    logic         out_last;
    logic         out_carry;
    logic         len_err;
    logic         busy;
`ifdef MULTIWORD_OVF_EN
    logic         out_ovf;
`endif

    multiword_add_seq #(.WIDTH(W), .WORDS(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .in_first(in_first), .in_last(in_last), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_last(out_last), .out_carry(out_carry),
        .len_err(len_err),
`ifdef MULTIWORD_OVF_EN
        .out_ovf(out_ovf),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         last;
        logic         carry;
        logic         err;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic         m_run = 1'b0;
    int           m_cnt = 0;
    logic         m_carry = 1'b0;
    logic         m_err = 1'b0;

    // Negedge: retire an output that the next edge will consume, then
    // predict the beat that the next edge will accept.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_run = 1'b0; m_cnt = 0; m_carry = 1'b0; m_err = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sum",   32'(out_sum),   32'(e.sum));
                    chk("last",  32'(out_last),  32'(e.last));
                    chk("carry", 32'(out_carry), 32'(e.carry));
                    chk("lerr",  32'(len_err),   32'(e.err));
`ifdef MULTIWORD_OVF_EN
                    chk("ovf",   32'(out_ovf),   32'(e.ovf));
`endif
                end
            end
            if (in_valid && in_ready) begin
                exp_t  e;
                logic  first, cin, last;
                int    cnt;
                logic [W:0] r;
                first = in_first || !m_run;
                if ((!in_first && !m_run) || (in_first && m_run)) m_err = 1'b1;
                cin  = first ? carry_in : m_carry;
                cnt  = first ? 0 : m_cnt;
                r    = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, cin};
                last = in_last || (cnt == N - 1);
                if (!in_last && cnt == N - 1) m_err = 1'b1;
                m_carry = r[W];
                if (last) begin m_run = 1'b0; m_cnt = 0; end
                else      begin m_run = 1'b1; m_cnt = cnt + 1; end
                e.sum   = r[W-1:0];
                e.last  = last;
                e.carry = last & r[W];
                e.err   = m_err;
                e.ovf   = last && (in_a[W-1] == in_b[W-1]) && (r[W-1] != in_a[W-1]);
                exp_q.push_back(e);
            end
        end
    end

    // Optional random downstream stall
    logic rnd_bp = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic f, input logic l, input logic ci);
        int n;
        in_a = a; in_b = b; in_first = f; in_last = l; carry_in = ci;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_vld",   32'(out_valid), 0);
        chk("rst_sum",   32'(out_sum),   0);
        chk("rst_last",  32'(out_last),  0);
        chk("rst_carry", 32'(out_carry), 0);
        chk("rst_lerr",  32'(len_err),   0);
        chk("rst_busy",  32'(busy),      0);
        chk("rst_rdy",   32'(in_ready),  1);
        @(posedge clk); #1;

        // Single word: FFFF+0001 -> 0000, carry 1
        send(16'hFFFF, 16'h0001, 1, 1, 0);
        @(negedge clk);
        chk("sw_sum",   32'(out_sum),   32'h0000);
        chk("sw_carry", 32'(out_carry), 1);
        chk("sw_last",  32'(out_last),  1);
        @(posedge clk); #1;

        // Two-word carry chain: 0000 then 0001
        send(16'hFFFF, 16'h0001, 1, 0, 0);
        chk("cc_busy", 32'(busy), 1);
        send(16'h0000, 16'h0000, 0, 1, 0);
        @(negedge clk);
        chk("cc_sum", 32'(out_sum), 32'h0001);
        chk("cc_busy_end", 32'(busy), 0);
        idle(2);

        // Back-pressure: stall 3 cycles after the first word
        send(16'h1234, 16'h1111, 1, 0, 0);
        out_ready = 1'b0;
        in_a = 16'hAAAA; in_b = 16'h5555; in_first = 0; in_last = 0; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_rdy", 32'(in_ready), 0);
            chk("bp_sum", 32'(out_sum),  32'h2345);
            chk("bp_vld", 32'(out_valid), 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        send(16'hAAAA, 16'h5555, 0, 0, 0);
        send(16'h0001, 16'h0002, 0, 1, 0);
        idle(2);

        // Reset after 2 of 3 beats
        send(16'h0101, 16'h0202, 1, 0, 0);
        send(16'h0303, 16'h0404, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mr_vld",  32'(out_valid), 0);
        chk("mr_sum",  32'(out_sum),   0);
        chk("mr_last", 32'(out_last),  0);
        chk("mr_busy", 32'(busy),      0);
        @(posedge clk); #1 rst = 1'b0;
        send(16'h0003, 16'h0004, 1, 1, 1);
        @(negedge clk);
        chk("mr_new_sum", 32'(out_sum), 32'h0008);
        @(posedge clk); #1;

        // Forced termination after N beats
        send(16'h8000, 16'h8000, 1, 0, 0);
        send(16'h0001, 16'h0001, 0, 0, 0);
        send(16'h0002, 16'h0002, 0, 0, 0);
        send(16'hFFFF, 16'h0000, 0, 0, 0);
        @(negedge clk);
        chk("ft_last", 32'(out_last), 1);
        chk("ft_lerr", 32'(len_err),  1);
        chk("ft_busy", 32'(busy),     0);
        @(posedge clk); #1;
        send(16'h0010, 16'h0020, 1, 1, 0);
        @(negedge clk);
        chk("ft_next", 32'(out_sum), 32'h0030);
        @(posedge clk); #1;

        // Clear len_err, then a beat without first in IDLE
        rst = 1'b1; idle(1); rst = 1'b0;
        send(16'h0005, 16'h0006, 0, 1, 1);
        @(negedge clk);
        chk("nf_sum",  32'(out_sum), 32'h000C);
        chk("nf_lerr", 32'(len_err), 1);
        @(posedge clk); #1;

        // Abort in RUN by a new first beat
        rst = 1'b1; idle(1); rst = 1'b0;
        send(16'hFFFF, 16'hFFFF, 1, 0, 0);
        send(16'h0007, 16'h0001, 1, 1, 0);
        @(negedge clk);
        chk("ab_sum",  32'(out_sum), 32'h0008);
        chk("ab_lerr", 32'(len_err), 1);
        @(posedge clk); #1;

`ifdef MULTIWORD_OVF_EN
        send(16'h7FFF, 16'h0001, 1, 1, 0);
        @(negedge clk);
        chk("ovf_pos", 32'(out_ovf), 1);
        @(posedge clk); #1;
        send(16'h8000, 16'h7FFF, 1, 1, 0);
        @(negedge clk);
        chk("ovf_mix", 32'(out_ovf), 0);
        @(posedge clk); #1;
`endif

        // Random operations with random stalls
        rnd_bp = 1'b1;
        for (int op = 0; op < 40; op++) begin
            int len;
            len = $urandom_range(1, N + 1);
            for (int k = 0; k < len; k++) begin
                send(W'($urandom), W'($urandom), (k == 0), (k == len - 1),
                     1'($urandom));
            end
        end
        rnd_bp = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        idle(4);
        chk("sb_drain", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multiword_add_seq.md
# multiword_add_seq

Sequential multi-word adder stage that streams long operands through a single WIDTH-bit ripple-carry word adder, one word pair per cycle, least-significant word first. Registers the inter-word carry, the produced sum word and the final carry. Sits directly around the 16-bit adder datapath: it feeds the adder each word pair with the chained carry and consumes its sum/carry to drive a registered valid/ready output stream.

## Interface

**Parameters**
- `WIDTH`, 16, word width in bits.
- `WORDS`, 4, maximum words per operation; counter width is clog2(WORDS).

**Ports**
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input word pair valid.
- `in_ready`  out  1  stage can accept a word pair.
- `in_a`, `in_b`  in  WIDTH  operand words.
- `in_first`  in  1  beat is the least-significant word of a new operation.
- `in_last`  in  1  beat is the most-significant word.
- `carry_in`  in  1  operation carry-in, sampled only on a first beat.
- `out_valid`  out  1  result word valid.
- `out_ready`  in  1  downstream accepts the result word.
- `out_sum`  out  WIDTH  sum word.
- `out_last`  out  1  result word is the final word.
- `out_carry`  out  1  final carry-out; meaningful only when `out_last`=1.
- `len_err`  out  1  sticky flag: operation exceeded WORDS or was started without `in_first`.
- `busy`  out  1  high in state RUN.

## Operation

- Input transfer: `in_valid && in_ready`. Output transfer: `out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`. Single output register, no skid buffer.
- Word adder: `{c, s} = in_a + in_b + cin`. On a first beat `cin = carry_in`; otherwise `cin = carry_q`.
- FSM has two states.
  - IDLE: accepts only beats with `in_first`=1. A beat without `in_first` is accepted, sets `len_err`, is treated as a first beat with `cin = carry_in`, and does not drop data.
  - RUN: entered after an accepted first beat that is not last. Stays in RUN while non-last beats are accepted. Returns to IDLE on an accepted last beat.
  - A first beat accepted while in RUN aborts the current operation and starts a new one without asserting `out_last` for the old operation. It also sets `len_err`.
- The effective last flag is `in_last`, or the word counter equal to WORDS-1. Forced termination sets `len_err`.
- On every accepted beat: load `out_sum=s` and `out_last`=effective last, and set `carry_q=c`. `out_carry=c` is loaded only when effective last; otherwise it holds 0.
- Word counter: cleared on a first beat, incremented on each accepted non-last beat, cleared on last. It never wraps past WORDS-1.
- `len_err` is cleared only by `rst`.

## Timing

- Latency: 1 cycle from input transfer to `out_valid`.
- Throughput: 1 word/cycle when `out_ready` is held high.
- Back-pressure: while `out_valid && !out_ready`, `in_ready`=0 and all output registers hold.
- Simultaneous output transfer and input transfer in the same cycle: the register reloads and `out_valid` stays 1.
- Reset values: `out_valid`=0, `out_sum`=0, `out_last`=0, `out_carry`=0, `len_err`=0, `busy`=0, `carry_q`=0, counter=0, state=IDLE. `in_ready`=1 the cycle after reset releases.
- Reset mid-operation: the partial result is discarded and no `out_last` is emitted.

## Configuration

- `MULTIWORD_OVF_EN` defined:
  - Adds output `out_ovf` (1 bit), reset 0.
  - Loaded on a last beat with the two's-complement overflow of the top word: `in_a[W-1] == in_b[W-1] && s[W-1] != in_a[W-1]`.
  - Holds 0 on non-last beats.
- `MULTIWORD_OVF_EN` undefined: the port and its logic are absent; all other behaviour is identical.

## Structure

- Shared package `multiword_add_pkg`:
  - state enum {IDLE, RUN};
  - default WIDTH/WORDS localparams;
  - counter-width function.
- One sub-module, `word_rca`: combinational WIDTH-bit ripple-carry word adder with carry in/out, instantiated once.
- FSM, counter, carry register and output register live in the top.

## Test plan

- **Single-word operation.** First+last beat, `a=16'hFFFF`, `b=16'h0001`, `carry_in=0` → next cycle `out_sum=16'h0000`, `out_last=1`, `out_carry=1`.
- **Carry chaining across words.** WIDTH=16, a 2-word operation: words (`16'hFFFF`,`16'h0001`) then (`16'h0000`,`16'h0000`) → `out_sum` 0x0000 then 0x0001, `out_carry=0`, `carry_q` propagated.
- **Back-pressure.** `out_ready=0` for 3 cycles mid-stream → `in_ready=0`, `out_sum` stable, no beat lost. Output order is preserved after release.
- **Forced termination.** WORDS=4, 4 beats without `in_last` → 4th result has `out_last=1` and `len_err=1`; the next first beat is accepted normally.
- **Reset mid-operation.** `rst` after 2 of 3 beats → all outputs 0 next cycle. A new single-word op `16'h0003+16'h0004` with `carry_in=1` gives `out_sum=16'h0008`.
- **`MULTIWORD_OVF_EN` build.** Last word `16'h7FFF+16'h0001` → `out_ovf=1`. `16'h8000+16'h7FFF` → `out_ovf=0`.
